// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I immediate generator (I/S/B/U/J/R) with pc+imm target,
// 1-cycle latency and a 2-entry output/skid buffer. Optional macro: IMM_GEN_ZIMM_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } ent_t;

  ent_t       dec_s;
  ent_t       out_r;
  ent_t       skid_r;
  logic       out_valid_r;
  logic       skid_valid_r;
  logic [6:0] opcode_s;
  logic       in_ready_s;
  logic       in_fire_s;
  logic       load_out_s;

  // Every format is first assembled as a 32-bit signed value, then widened to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
    return sext32({{20{i[31]}}, i[31:20]});
  endfunction

  assign opcode_s   = in_instr[6:0];
  assign in_ready_s = !skid_valid_r && !reset;
  assign in_fire_s  = in_valid && in_ready_s;
  assign load_out_s = !out_valid_r || out_ready;

  // Opcode decode: format, extended immediate, illegal flag and branch/jump target.
  always_comb begin
    dec_s         = '0;
    dec_s.instr   = in_instr;
    dec_s.imm     = {XLEN{1'b0}};
    dec_s.fmt     = FMT_ILL;
    dec_s.illegal = 1'b0;
    case (opcode_s)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        dec_s.fmt = FMT_I;
        dec_s.imm = imm_i(in_instr);
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
        if (in_instr[14]) begin
          dec_s.fmt = FMT_Z;
          dec_s.imm = XLEN'({27'd0, in_instr[19:15]});
        end else begin
          dec_s.fmt = FMT_I;
          dec_s.imm = imm_i(in_instr);
        end
`else
        dec_s.fmt = FMT_I;
        dec_s.imm = imm_i(in_instr);
`endif
      end
      7'b0100011: begin
        dec_s.fmt = FMT_S;
        dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec_s.fmt = FMT_B;
        dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec_s.fmt = FMT_U;
        dec_s.imm = sext32({in_instr[31:12], 12'h000});
      end
      7'b1101111: begin
        dec_s.fmt = FMT_J;
        dec_s.imm = sext32({{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0});
      end
      7'b0110011: begin
        dec_s.fmt = FMT_R;
        dec_s.imm = {XLEN{1'b0}};
      end
      default: begin
        dec_s.fmt     = FMT_ILL;
        dec_s.imm     = {XLEN{1'b0}};
        dec_s.illegal = 1'b1;
      end
    endcase
    dec_s.target = in_pc + dec_s.imm;
  end

  // Output register plus skid entry; skid always drains into the output before new input.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (load_out_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        out_r       <= dec_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_instr   = out_r.instr;
  assign out_imm     = out_r.imm;
  assign out_fmt     = out_r.fmt;
  assign out_target  = out_r.target;
  assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table + scoreboard queue, plus
// backpressure, flush and mid-operation reset sequences.
module tb_imm_gen_pipe;
  localparam int XLEN = 32;
  localparam int NV   = 14;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_imm, out_target;
  logic [2:0]      out_fmt;

  imm_gen_pipe #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            ill;
  } vec_t;

  vec_t tbl[NV];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_done;

  function automatic vec_t mk(input logic [31:0] i, input logic [XLEN-1:0] p,
                              input logic [XLEN-1:0] im, input logic [2:0] f, input logic il);
    vec_t r;
    r.instr = i; r.pc = p; r.imm = im; r.fmt = f; r.ill = il;
    r.target = p + im;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: an output transfer happens on the coming edge when both are high here.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got instr 0x%0h expected none", out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_instr",   64'(out_instr),   64'(e.instr));
        chk("out_imm",     64'(out_imm),     64'(e.imm));
        chk("out_fmt",     64'(out_fmt),     64'(e.fmt));
        chk("out_target",  64'(out_target),  64'(e.target));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
      end
    end
  end

  task automatic send(input vec_t v, output int waited);
    bit done = 1'b0;
    waited   = 0;
    in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush) sb.push_back(v);
        done = 1'b1;
      end else if (waited >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected accept", waited);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && c < 40) begin
      @(posedge clk); #1; c++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    tbl[0]  = mk(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 1'b0);
    tbl[1]  = mk(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3'd3, 1'b0);
    tbl[2]  = mk(32'h123450B7, 32'h0000_0000, 32'h1234_5000, 3'd4, 1'b0);
    tbl[3]  = mk(32'h001000EF, 32'h0000_1000, 32'h0000_0800, 3'd5, 1'b0);
    tbl[4]  = mk(32'h0000007F, 32'h0000_0040, 32'h0000_0000, 3'd7, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    tbl[5]  = mk(32'h3401D073, 32'h0000_2000, 32'h0000_0003, 3'd6, 1'b0);
`else
    tbl[5]  = mk(32'h3401D073, 32'h0000_2000, 32'h0000_0340, 3'd1, 1'b0);
`endif
    tbl[6]  = mk(32'hFE112C23, 32'h0000_0010, 32'hFFFF_FFF8, 3'd2, 1'b0);
    tbl[7]  = mk(32'h002081B3, 32'h0000_0300, 32'h0000_0000, 3'd0, 1'b0);
    tbl[8]  = mk(32'hFFFFF117, 32'h0000_5000, 32'hFFFF_F000, 3'd4, 1'b0);
    tbl[9]  = mk(32'h7FF00093, 32'hFFFF_FFF0, 32'h0000_07FF, 3'd1, 1'b0);
    tbl[10] = mk(32'h34029073, 32'h0000_0000, 32'h0000_0340, 3'd1, 1'b0);
    tbl[11] = mk(32'hFFDFF0EF, 32'h0000_0020, 32'hFFFF_FFFC, 3'd5, 1'b0);
    tbl[12] = mk(32'h00812083, 32'h0000_0000, 32'h0000_0008, 3'd1, 1'b0);
    tbl[13] = mk(32'h00000000, 32'h0000_0004, 32'h0000_0000, 3'd7, 1'b1);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_fmt",   64'(out_fmt),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Table phase: first item checks 1-cycle latency, the rest go back to back.
    out_ready = 1'b1;
    send(tbl[0], w);
    @(negedge clk);
    chk("latency1_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    for (int i = 1; i < NV; i++) begin
      send(tbl[i], w);
      chk("b2b_wait", 64'(w), 64'd0);
    end
    drain();

    // Backpressure: two accepted, then in_ready drops and output holds.
    out_ready = 1'b0;
    send(tbl[0], w);
    send(tbl[1], w);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      begin
        send(tbl[2], w);
        send(tbl[3], w);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_instr", 64'(out_instr), 64'(tbl[0].instr));
          chk("stall_imm",   64'(out_imm),   64'(tbl[0].imm));
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with one entry pending; input in the flush cycle is discarded.
    out_ready = 1'b0;
    send(tbl[4], w);
    flush = 1'b1;
    send(tbl[5], w);
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 drain();

    // Flush with both entries full.
    out_ready = 1'b0;
    send(tbl[6], w);
    send(tbl[7], w);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    chk("flush2_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    drain();

    // Reset mid-operation with both entries full, dominating a concurrent flush.
    out_ready = 1'b0;
    send(tbl[8], w);
    send(tbl[9], w);
    reset = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    sb.delete();
    flush = 1'b0;
    chk("midrst_out_valid",  64'(out_valid),  64'd0);
    chk("midrst_out_imm",    64'(out_imm),    64'd0);
    chk("midrst_out_target", 64'(out_target), 64'd0);
    chk("midrst_out_instr",  64'(out_instr),  64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_after_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Random backpressure stream: ordering, no loss, no duplicate.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(tbl[$urandom_range(0, NV - 1)], w);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
